toom8_recompose: RTL

- Final stage of the TOOM-8 1024x1024 multiplier datapath.
- Consumes the 15 interpolated product coefficients c0..c14 that come out of the interpolation stage, which follows pointwise multiplication.
- Streams them in one per accepted beat and performs the overlap-add `product = sum c_i * 2^(128*i)` with a limb-serial carry chain.
- Presents the 2048-bit product with a valid/ready handshake.

---
 rtl/toom8_recompose_if.sv | 33 +++
 rtl/toom8_recompose.sv | 118 +++++++++++
 2 files changed

// File: rtl/toom8_recompose_if.sv
// Coefficient-in / product-out bus of the TOOM-8 recomposition stage.
//   coef_in/coef_valid/coef_ready : signed coefficient stream, one c_i per beat
//   coef_idx                      : index of the next coefficient expected
//   product/out_valid/out_ready   : recomposed product handshake
//   ovf                           : final carry did not fit, valid with out_valid
// master = coefficient producer / product consumer, slave = recomposer.
interface toom8_recompose_if #(
    parameter int unsigned LIMB_W   = 128,
    parameter int unsigned NUM_COEF = 15,
    parameter int unsigned COEF_W   = 264
);
    localparam int unsigned PROD_W = LIMB_W * (NUM_COEF + 1);
    localparam int unsigned IDX_W  = 4;

    logic [COEF_W-1:0] coef_in;
    logic              coef_valid;
    logic              coef_ready;
    logic [IDX_W-1:0]  coef_idx;
    logic [PROD_W-1:0] product;
    logic              out_valid;
    logic              out_ready;
    logic              ovf;

    modport master (
        output coef_in, coef_valid, out_ready,
        input  coef_ready, coef_idx, product, out_valid, ovf
    );

    modport slave (
        input  coef_in, coef_valid, out_ready,
        output coef_ready, coef_idx, product, out_valid, ovf
    );
endinterface

// File: rtl/toom8_recompose.sv
// Final stage of the TOOM-8 1024x1024 multiplier: overlap-adds the 15 signed
// interpolated coefficients as product = sum c_i * 2^(LIMB_W*i) with a
// limb-serial carry chain, then presents the PROD_W-bit product.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous abort of the current accumulation
//   bus        : slave side of toom8_recompose_if (coefficient in, product out)
module toom8_recompose #(
    parameter int unsigned LIMB_W   = 128,
    parameter int unsigned NUM_COEF = 15,
    parameter int unsigned COEF_W   = 264
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    toom8_recompose_if.slave  bus
);
    localparam int unsigned PROD_W  = LIMB_W * (NUM_COEF + 1);
    localparam int unsigned CARRY_W = COEF_W - LIMB_W + 1;
    localparam int unsigned SUM_W   = COEF_W + 1;
    localparam int unsigned IDX_W   = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEF - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {ACCUM, FLUSH, DONE} state_t;

    state_t              state_q;
    state_t              state_d;
    logic                rdy_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CARRY_W-1:0]  carry_q;
    logic [PROD_W-1:0]   product_q;
    logic                out_valid_q;
    logic                ovf_q;
    logic                beat_c;
    logic [SUM_W-1:0]    sum_c;

    // rdy_q is registered so ready stays low while in reset; clear drops it
    // combinationally so a beat offered alongside clear is never accepted.
    assign bus.coef_ready = rdy_q & ~clear;
    assign beat_c         = bus.coef_valid & bus.coef_ready;

    assign bus.coef_idx  = idx_q;
    assign bus.product   = product_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;

    // Sign-extended coefficient plus sign-extended carry; upper bits are the
    // arithmetic right shift by LIMB_W that forms the next carry.
    assign sum_c = {bus.coef_in[COEF_W-1], bus.coef_in}
                 + {{(SUM_W - CARRY_W){carry_q[CARRY_W-1]}}, carry_q};

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (beat_c && idx_q == LAST_IDX) state_d = FLUSH;
                FLUSH:   state_d = DONE;
                DONE:    if (bus.out_ready) state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == ACCUM);
        end
    end

    // Limb write-back, carry chain and output flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            carry_q     <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (clear) begin
            idx_q       <= '0;
            carry_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (beat_c) begin
                        product_q[idx_q*LIMB_W +: LIMB_W] <= sum_c[LIMB_W-1:0];
                        carry_q <= sum_c[SUM_W-1:LIMB_W];
                        idx_q   <= idx_q + IDX_ONE;
                    end
                end
                FLUSH: begin
                    // Bits above the top limb (sign included) mean the result
                    // does not fit, whether it overflowed upward or went negative.
                    product_q[PROD_W-1 -: LIMB_W] <= carry_q[LIMB_W-1:0];
                    ovf_q       <= |carry_q[CARRY_W-1:LIMB_W];
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        carry_q     <= '0;
                        idx_q       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
